ysyx_23060042_exu_pipe: RTL and testbench
=========================================

# ysyx_23060042_exu_pipe

Parametrised, handshaked execute stage for the NPC core, succeeding the single-cycle combinational execute unit. It accepts one decoded instruction per valid/ready transfer, computes the ALU result, branch decision and branch target, and holds the result in a one-entry output register. It supports an optional iterative multiplier. Halt (ebreak) is reported as a registered output with sticky halted state instead of an in-block call.

## Interface
- `XLEN`, default 32: datapath width; must be ≥ 8 and a power of 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock domain.
- `in_valid`  in  1  upstream record valid.
- `in_ready`  out  1  stage can accept a record this cycle.
- `in_pc`  in  XLEN  instruction PC.
- `in_op`  in  4  ALU op; when `in_brch`=1, `in_op[2:0]` is the branch funct3.
- `in_src1`, `in_src2`, `in_imm`  in  XLEN  register operands and immediate.
- `in_sel_pc`  in  1  operand A = `in_pc` (else `in_src1`).
- `in_sel_imm`  in  1  operand B = `in_imm` (else `in_src2`).
- `in_brch`  in  1  conditional branch.
- `in_brk`  in  1  ebreak; halt code is `in_src1` (a0).
- `out_valid`  out  1  result record valid.
- `out_ready`  in  1  downstream accepts the record.
- `out_wdata`  out  XLEN  writeback data.
- `out_brch_taken`  out  1  branch taken.
- `out_brch_target`  out  XLEN  `in_pc + in_imm`, mod 2^XLEN.
- `out_halt`  out  1  record is an ebreak.
- `out_halt_code`  out  XLEN  a0 at the ebreak.

## Operation
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is `B[$clog2(XLEN)-1:0]`.
  - 8 SLT (signed), 9 SLTU (result 0/1 zero-extended).
  - 10 MUL (low XLEN bits of the product).
  - 11–15: result 0.
- Branch (`in_brch`=1), by funct3:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 are never taken.
  - Compare uses `in_src1` vs `in_src2`. `out_wdata`=0.
- Non-branch: `out_brch_taken`=0; `out_brch_target` is still computed.
- `in_brk`: `out_halt`=1, `out_halt_code`=`in_src1`, `out_wdata`=0.
- State machine:
  - IDLE: on accept, single-cycle ops load the output register and stay in IDLE. MUL (macro enabled) latches the operands and goes to BUSY with count=0.
  - BUSY: one shift-add step per cycle; after step XLEN-1, load the output register and go to IDLE.
  - HALTED: entered when an `out_halt` record is transferred (`out_valid & out_ready`). `in_ready`=0 and `out_valid`=0 until reset.
- `in_ready` = (state==IDLE) & (!`out_valid` | `out_ready`).
  - A result may be consumed and a new record accepted in the same cycle (full throughput).
  - MUL is not accepted while an unconsumed result is held.
- Output register holds all fields stable while `out_valid` & !`out_ready`.
- Reset (any time, including mid-MUL):
  - state IDLE, count 0, all outputs 0.
  - `in_ready` reads 1 once `rst_n` is high; any in-flight MUL is discarded.

## Timing
- Single-cycle op: accept at edge N → `out_valid`=1 after edge N, i.e. latency 1.
- MUL: accept at edge N → `out_valid` after edge N+XLEN; `in_ready`=0 during BUSY.
- `out_valid` falls after the transfer edge unless a new record is accepted at that edge.
- No combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally on `out_ready`.

## Configuration
- `YSYX_23060042_MUL_EN` defined:
  - op 10 uses the iterative multiplier and BUSY state.
  - Latency XLEN+1 from accept to transfer-ready.
- Not defined:
  - no multiplier logic and no BUSY state.
  - op 10 behaves as ops 11–15: result 0, latency 1.

## Test plan
- ADD, XLEN=32: src1=5, imm=0xFFFFFFFD, `in_sel_imm`=1 → next cycle `out_valid`=1, `out_wdata`=2.
- Backpressure: `out_ready`=0 for 3 cycles after ADD(1,2) → `out_wdata`=3 held stable, `in_ready`=0. Raise `out_ready` together with a valid SUB(9,4) → same-cycle transfer, next `out_wdata`=5.
- Branch BLT: src1=0xFFFFFFFF, src2=1, pc=0x80000000, imm=0x10 → taken=1, target=0x80000010. BLTU with the same operands → taken=0.
- MUL (macro on): 7×6 → `in_ready`=0 for 32 cycles, then `out_wdata`=42. Macro off: result 0 after 1 cycle.
- Halt: ebreak with src1=0 → `out_halt`=1, code=0. After transfer, `in_ready` stays 0 with `in_valid`=1 for 10 cycles. Pulse `rst_n` → `in_ready`=1.
- Reset mid-MUL: assert `rst_n`=0 at BUSY step 10 → `out_valid`=0 and all outputs 0 immediately. After release, ADD(1,1) → `out_wdata`=2 after 1 cycle.

Source files
------------

// File: rtl/ysyx_23060042_exu_pipe_if.sv
// rtl/ysyx_23060042_exu_pipe_if.sv - handshake bundle between decode, execute stage and writeback
// slave is the execute stage; master is whoever drives records in and consumes results
interface ysyx_23060042_exu_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_imm;
  logic            in_sel_pc;
  logic            in_sel_imm;
  logic            in_brch;
  logic            in_brk;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_wdata;
  logic            out_brch_taken;
  logic [XLEN-1:0] out_brch_target;
  logic            out_halt;
  logic [XLEN-1:0] out_halt_code;

  modport slave (
    input  in_valid, in_pc, in_op, in_src1, in_src2, in_imm,
           in_sel_pc, in_sel_imm, in_brch, in_brk, out_ready,
    output in_ready, out_valid, out_wdata, out_brch_taken,
           out_brch_target, out_halt, out_halt_code
  );

  modport master (
    output in_valid, in_pc, in_op, in_src1, in_src2, in_imm,
           in_sel_pc, in_sel_imm, in_brch, in_brk, out_ready,
    input  in_ready, out_valid, out_wdata, out_brch_taken,
           out_brch_target, out_halt, out_halt_code
  );
endinterface

// File: rtl/ysyx_23060042_exu_pipe.sv
// rtl/ysyx_23060042_exu_pipe.sv - handshaked execute stage with one-entry result register
// Optional iterative multiplier for op 10 is enabled by defining YSYX_23060042_MUL_EN.
module ysyx_23060042_exu_pipe #(
  parameter int XLEN = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  ysyx_23060042_exu_pipe_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] IDLE   = 2'd0;
`ifdef YSYX_23060042_MUL_EN
  localparam logic [1:0] BUSY   = 2'd1;
`endif
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]      state;
  logic            out_valid_q;
  logic [XLEN-1:0] out_wdata_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic            halt_q;
  logic [XLEN-1:0] code_q;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res_wdata;
  logic [XLEN-1:0] target;
  logic [SHW-1:0]  shamt;
  logic            taken;
  logic            accept;
  logic            is_mul;
  logic            halt_xfer;

  assign op_a   = bus.in_sel_pc  ? bus.in_pc  : bus.in_src1;
  assign op_b   = bus.in_sel_imm ? bus.in_imm : bus.in_src2;
  assign shamt  = op_b[SHW-1:0];
  assign target = bus.in_pc + bus.in_imm;

  always_comb begin
    alu_res = '0;
    case (bus.in_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  // Branch compares always use the register operands, never the muxed ALU inputs.
  always_comb begin
    taken = 1'b0;
    if (bus.in_brch) begin
      case (bus.in_op[2:0])
        3'b000:  taken = bus.in_src1 == bus.in_src2;
        3'b001:  taken = bus.in_src1 != bus.in_src2;
        3'b100:  taken = $signed(bus.in_src1) <  $signed(bus.in_src2);
        3'b101:  taken = $signed(bus.in_src1) >= $signed(bus.in_src2);
        3'b110:  taken = bus.in_src1 <  bus.in_src2;
        3'b111:  taken = bus.in_src1 >= bus.in_src2;
        default: taken = 1'b0;
      endcase
    end
  end

  assign res_wdata = (bus.in_brch | bus.in_brk) ? '0 : alu_res;

  assign bus.in_ready = (state == IDLE) & (!out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign halt_xfer    = out_valid_q & bus.out_ready & halt_q;

`ifdef YSYX_23060042_MUL_EN
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;

  assign is_mul   = (bus.in_op == 4'd10) & !bus.in_brch & !bus.in_brk;
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);
`else
  assign is_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_wdata_q <= '0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      halt_q      <= 1'b0;
      code_q      <= '0;
`ifdef YSYX_23060042_MUL_EN
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A halt transfer wins: anything accepted on the same edge is dropped.
          if (halt_xfer) begin
            state       <= HALTED;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            taken_q  <= taken;
            target_q <= target;
            halt_q   <= bus.in_brk;
            code_q   <= bus.in_brk ? bus.in_src1 : '0;
            if (is_mul) begin
              out_valid_q <= 1'b0;
`ifdef YSYX_23060042_MUL_EN
              state <= BUSY;
              cnt   <= '0;
              mul_a <= op_a;
              mul_b <= op_b;
              acc   <= '0;
`endif
            end else begin
              out_valid_q <= 1'b1;
              out_wdata_q <= res_wdata;
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
`ifdef YSYX_23060042_MUL_EN
        BUSY: begin
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            out_wdata_q <= acc_next;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
`endif
        HALTED: out_valid_q <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.out_wdata       = out_wdata_q;
  assign bus.out_brch_taken  = taken_q;
  assign bus.out_brch_target = target_q;
  assign bus.out_halt        = halt_q;
  assign bus.out_halt_code   = code_q;
endmodule

// File: tb/tb_ysyx_23060042_exu_pipe.sv
// tb/tb_ysyx_23060042_exu_pipe.sv - directed self-checking bench for the execute stage
module tb_ysyx_23060042_exu_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060042_exu_pipe_if #(.XLEN(32)) bus ();

  ysyx_23060042_exu_pipe #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic set_rec(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic sp,
                         input logic si, input logic br, input logic bk);
    bus.in_op      = op;
    bus.in_src1    = s1;
    bus.in_src2    = s2;
    bus.in_imm     = imm;
    bus.in_pc      = pc;
    bus.in_sel_pc  = sp;
    bus.in_sel_imm = si;
    bus.in_brch    = br;
    bus.in_brk     = bk;
    bus.in_valid   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_rec(4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_wdata, bus.out_brch_taken, bus.out_brch_target,
         bus.out_halt, bus.out_halt_code} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%0b wdata=%h halt=%0b", bus.out_valid, bus.out_wdata, bus.out_halt);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    @(negedge clk);
    set_rec(4'd0, 32'd5, 32'd99, 32'hFFFF_FFFD, 32'h100, 0, 1, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd2) begin
      n_bad++;
      $display("FAIL add got valid=%0b wdata=%h want 1/00000002", bus.out_valid, bus.out_wdata);
    end
    n_cmp++;
    if (bus.out_brch_taken !== 1'b0 || bus.out_brch_target !== 32'h0000_00FD) begin
      n_bad++;
      $display("FAIL add_target got taken=%0b target=%h want 0/000000fd", bus.out_brch_taken, bus.out_brch_target);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_drop got valid=%0b want 0", bus.out_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  ops [11] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd12, 4'd0};
    logic [31:0] s1  [11] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000, 32'h1, 32'h8000_0000,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h55, 32'h0};
    logic [31:0] s2  [11] = '{32'h0FF0_FFFF, 32'hF, 32'h0F0F_0F0F, 32'h3F, 32'd4, 32'd4, 32'd1,
                              32'd1, 32'd5, 32'h66, 32'h0};
    logic [31:0] exp [11] = '{32'h00F0_1234, 32'hF000_000F, 32'hF0F0_0F0F, 32'h8000_0000,
                              32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'd0,
                              32'h0000_1004};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 10) set_rec(ops[i], s1[i], s2[i], 32'd4, 32'h1000, 1, 1, 0, 0);
      else         set_rec(ops[i], s1[i], s2[i], 32'd0, 32'h0, 0, 0, 0, 0);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_wdata !== exp[i]) begin
        n_bad++;
        $display("FAIL op%0d got valid=%0b wdata=%h want %h", ops[i], bus.out_valid, bus.out_wdata, exp[i]);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready = 1'b0;
    set_rec(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd3 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold%0d got valid=%0b wdata=%h in_ready=%0b want 1/3/0", i, bus.out_valid, bus.out_wdata, bus.in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_rec(4'd1, 32'd9, 32'd4, 32'd0, 32'd0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_ready got %0b want 1", bus.in_ready);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd5) begin
      n_bad++;
      $display("FAIL sub_after_hold got valid=%0b wdata=%h want 1/5", bus.out_valid, bus.out_wdata);
    end
    @(posedge clk);
  endtask

  task automatic test_branch();
    logic [2:0] f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b010};
    logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_rec({1'b0, f3[i]}, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h8000_0000, 0, 0, 1, 0);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_brch_taken !== exp[i] ||
          bus.out_brch_target !== 32'h8000_0010 || bus.out_wdata !== 32'd0) begin
        n_bad++;
        $display("FAIL branch_f3_%0d got taken=%0b target=%h wdata=%h want %0b/80000010/0",
                 f3[i], bus.out_brch_taken, bus.out_brch_target, bus.out_wdata, exp[i]);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_mul();
    @(negedge clk);
    set_rec(4'd10, 32'd7, 32'd6, 32'd0, 32'd0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
`ifdef YSYX_23060042_MUL_EN
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_busy%0d got in_ready=%0b valid=%0b want 0/0", i, bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd42) begin
      n_bad++;
      $display("FAIL mul got valid=%0b wdata=%h want 1/0000002a", bus.out_valid, bus.out_wdata);
    end
`else
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL mul_off got valid=%0b wdata=%h want 1/0", bus.out_valid, bus.out_wdata);
    end
`endif
    @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
`ifdef YSYX_23060042_MUL_EN
    set_rec(4'd10, 32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
`else
    bus.out_ready = 1'b0;
    set_rec(4'd0, 32'd3, 32'd4, 32'h20, 32'h40, 0, 0, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_wdata, bus.out_brch_taken, bus.out_brch_target,
         bus.out_halt, bus.out_halt_code} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got valid=%0b wdata=%h target=%h", bus.out_valid, bus.out_wdata, bus.out_brch_target);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL post_reset%0d got valid=%0b in_ready=%0b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    set_rec(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0, 0, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd2) begin
      n_bad++;
      $display("FAIL add_after_reset got valid=%0b wdata=%h want 1/2", bus.out_valid, bus.out_wdata);
    end
    @(posedge clk);
  endtask

  task automatic test_halt(input logic [31:0] code);
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_rec(4'd0, code, 32'd3, 32'd0, 32'd0, 0, 0, 0, 1);
    @(posedge clk); #1;
    set_rec(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_halt !== 1'b1 || bus.out_halt_code !== code ||
        bus.out_wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL halt got valid=%0b halt=%0b code=%h wdata=%h want 1/1/%h/0",
               bus.out_valid, bus.out_halt, bus.out_halt_code, bus.out_wdata, code);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL halted%0d got in_ready=%0b valid=%0b want 0/0", i, bus.in_ready, bus.out_valid);
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_halt !== 1'b0) begin
      n_bad++;
      $display("FAIL unhalt got in_ready=%0b halt=%0b want 1/0", bus.in_ready, bus.out_halt);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_backpressure();
    test_branch();
    test_mul();
    test_reset_mid_op();
    test_halt(32'd0);
    test_halt(32'h0000_0055);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
